// File: rtl/seg_pkg.sv
//------------------------------------------------------------------------------
// seg_pkg : shared glyph constants and sizing helpers for the seven-segment
//           scan driver.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

  localparam int SEG_W = 8;

  typedef logic [6:0] glyph_t;

  // Active-high a..g, bit 6 = a
  localparam glyph_t SEG_0   = 7'b1111110;
  localparam glyph_t SEG_1   = 7'b0110000;
  localparam glyph_t SEG_2   = 7'b1101101;
  localparam glyph_t SEG_3   = 7'b1111001;
  localparam glyph_t SEG_4   = 7'b0110011;
  localparam glyph_t SEG_5   = 7'b1011011;
  localparam glyph_t SEG_6   = 7'b1011111;
  localparam glyph_t SEG_7   = 7'b1110000;
  localparam glyph_t SEG_8   = 7'b1111111;
  localparam glyph_t SEG_9   = 7'b1111011;
  localparam glyph_t SEG_A   = 7'b1110111;
  localparam glyph_t SEG_B   = 7'b0011111;
  localparam glyph_t SEG_C   = 7'b1001110;
  localparam glyph_t SEG_D   = 7'b0111101;
  localparam glyph_t SEG_E   = 7'b1001111;
  localparam glyph_t SEG_F   = 7'b1000111;
  localparam glyph_t SEG_OFF = 7'b0000000;

  // Counter width that stays legal when the range collapses to one value
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
//------------------------------------------------------------------------------
// seg7_decode : nibble to active-high a..g glyph lookup.
//               Define SEG_HEX_EN to show A-F for nibbles 10-15.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output glyph_t     glyph
);

  always_comb begin
    glyph = SEG_OFF;
    case (nib)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
`ifdef SEG_HEX_EN
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      4'hF: glyph = SEG_F;
`endif
      default: glyph = SEG_OFF;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
//------------------------------------------------------------------------------
// seg_scan_driver : time-multiplexed common-anode seven-segment scanner with
//                   per-frame value snapshot and leading-zero blanking.
//                   Hex glyphs A-F enabled by defining SEG_HEX_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NDIG = 8,
  parameter int DIV  = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [4*NDIG-1:0] val,
  input  logic [NDIG-1:0]   dp,
  input  logic              blank_lz,
  output logic [SEG_W-1:0]  seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int CW = clog2_min1(DIV);
  localparam int IW = clog2_min1(NDIG);

  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [4*NDIG-1:0] r_sval;
  logic [NDIG-1:0]   r_sdp;
  logic              r_pend;

  logic              w_tick;
  logic              w_wrap;
  logic [3:0]        w_nib;
  logic              w_dp;
  logic              w_blank;
  logic              w_allz;
  glyph_t            w_glyph;
  glyph_t            w_glyph_show;
  logic [NDIG-1:0]   w_an_sel;

  assign w_tick = en && (r_cnt == CW'(DIV - 1));
  assign w_wrap = w_tick && (r_idx == IW'(NDIG - 1));

  // Walk from the most significant digit down so w_allz means "this digit
  // and everything to its left is zero" at the point the current index hits.
  always_comb begin
    w_nib   = 4'd0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    w_allz  = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      w_allz = w_allz && (r_sval[4*i +: 4] == 4'd0);
      if (r_idx == IW'(i)) begin
        w_nib   = r_sval[4*i +: 4];
        w_dp    = r_sdp[i];
        w_blank = blank_lz && (i != 0) && w_allz;
      end
    end
  end

  seg7_decode u_decode (
    .nib   (w_nib),
    .glyph (w_glyph)
  );

  assign w_glyph_show = w_blank ? SEG_OFF : w_glyph;
  assign w_an_sel     = NDIG'(1) << r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_sval     <= val;
      r_sdp      <= dp;
      r_pend     <= 1'b0;
      an         <= '1;
      seg        <= '1;
      frame_done <= 1'b0;
    end else begin
      if (en) begin
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        if (w_tick) begin
          r_idx <= w_wrap ? '0 : r_idx + 1'b1;
        end
      end
      if (w_wrap) begin
        r_sval <= val;
        r_sdp  <= dp;
      end
      // Pulse lines up with the output register returning to digit 0
      r_pend     <= w_wrap | (r_pend & ~en);
      frame_done <= en & r_pend;
      if (en) begin
        an  <= ~w_an_sel;
        seg <= ~{w_glyph_show, w_dp};
      end else begin
        an  <= '1;
        seg <= '1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
//------------------------------------------------------------------------------
// tb_seg_scan_driver : directed self-checking bench for seg_scan_driver.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] val = 16'h0000;
  logic [3:0]  dp = 4'b0000;
  logic        blank_lz = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  logic [3:0]  val1 = 4'h7;
  logic [0:0]  dp1 = 1'b1;
  logic [7:0]  seg1;
  logic [0:0]  an1;
  logic        frame_done1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.NDIG(4), .DIV(3)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .val        (val),
    .dp         (dp),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  seg_scan_driver #(.NDIG(1), .DIV(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .val        (val1),
    .dp         (dp1),
    .blank_lz   (blank_lz),
    .seg        (seg1),
    .an         (an1),
    .frame_done (frame_done1)
  );

  // Inverted {glyph,dp=0} for digits of 16'h1234, digit 0 first
  logic [7:0] seg1234 [4] = '{8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; val = 16'h1234; dp = 4'b0000; blank_lz = 1'b0;
    do_reset();
    checks++;
    if (an !== 4'b1111 || seg !== 8'hFF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset an=%b seg=%b fd=%b exp an=1111 seg=11111111 fd=0", an, seg, frame_done);
    end
  endtask

  task automatic test_scan();
    logic [3:0] one;
    logic [3:0] exp_an;
    logic       exp_fd;
    int         d;
    one = 4'b0001;
    en = 1'b1; val = 16'h1234; dp = 4'b0000; blank_lz = 1'b0;
    do_reset();
    for (int k = 1; k <= 25; k++) begin
      step();
      d      = ((k - 1) / 3) % 4;
      exp_an = ~(one << d);
      exp_fd = (k > 1) && (((k - 1) % 12) == 0);
      checks++;
      if (an !== exp_an || seg !== seg1234[d] || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL scan k=%0d an=%b seg=%b fd=%b exp an=%b seg=%b fd=%b",
                 k, an, seg, frame_done, exp_an, seg1234[d], exp_fd);
      end
    end
  endtask

  task automatic test_blank();
    logic [7:0] exp_seg [4];
    logic [3:0] exp_an [4];
    exp_seg = '{8'b00000011, 8'b01001001, 8'hFE, 8'hFF};
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    en = 1'b1; val = 16'h0050; dp = 4'b0100; blank_lz = 1'b1;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step();
      if (((k - 1) % 3) == 0) begin
        checks++;
        if (an !== exp_an[(k-1)/3] || seg !== exp_seg[(k-1)/3]) begin
          errors++;
          $display("FAIL blank k=%0d an=%b seg=%b exp an=%b seg=%b",
                   k, an, seg, exp_an[(k-1)/3], exp_seg[(k-1)/3]);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_shadow();
    en = 1'b1; val = 16'h1234; dp = 4'b0000; blank_lz = 1'b0;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 4) val = 16'h5678;
      if (k == 7 || k == 10 || k == 12) begin
        checks++;
        if (seg !== seg1234[(k-1)/3]) begin
          errors++;
          $display("FAIL shadow_hold k=%0d seg=%b exp=%b", k, seg, seg1234[(k-1)/3]);
        end
      end
      if (k == 13) begin
        checks++;
        if (an !== 4'b1110 || seg !== 8'b00000001 || frame_done !== 1'b1) begin
          errors++;
          $display("FAIL shadow_new k=13 an=%b seg=%b fd=%b exp an=1110 seg=00000001 fd=1", an, seg, frame_done);
        end
      end
      if (k == 16) begin
        checks++;
        if (an !== 4'b1101 || seg !== 8'b00011111) begin
          errors++;
          $display("FAIL shadow_d1 k=16 an=%b seg=%b exp an=1101 seg=00011111", an, seg);
        end
      end
    end
  endtask

  task automatic test_enable();
    en = 1'b1; val = 16'h1234; dp = 4'b0000; blank_lz = 1'b0;
    do_reset();
    for (int k = 1; k <= 7; k++) step();
    en = 1'b0;
    for (int k = 8; k <= 12; k++) begin
      step();
      checks++;
      if (an !== 4'b1111 || seg !== 8'hFF || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL en_off k=%0d an=%b seg=%b fd=%b exp an=1111 seg=11111111 fd=0", k, an, seg, frame_done);
      end
    end
    en = 1'b1;
    for (int k = 13; k <= 18; k++) begin
      logic [3:0] exp_an;
      logic [7:0] exp_seg;
      step();
      exp_an  = (k <= 14) ? 4'b1011 : (k <= 17) ? 4'b0111 : 4'b1110;
      exp_seg = (k <= 14) ? seg1234[2] : (k <= 17) ? seg1234[3] : seg1234[0];
      checks++;
      if (an !== exp_an || seg !== exp_seg || frame_done !== (k == 18)) begin
        errors++;
        $display("FAIL en_resume k=%0d an=%b seg=%b fd=%b exp an=%b seg=%b fd=%b",
                 k, an, seg, frame_done, exp_an, exp_seg, (k == 18));
      end
    end
  endtask

  task automatic test_rst_mid();
    en = 1'b1; val = 16'h1234; dp = 4'b0000; blank_lz = 1'b0;
    do_reset();
    for (int k = 1; k <= 5; k++) step();
    rst = 1'b1; val = 16'h0009;
    step();
    checks++;
    if (an !== 4'b1111 || seg !== 8'hFF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid an=%b seg=%b fd=%b exp an=1111 seg=11111111 fd=0", an, seg, frame_done);
    end
    rst = 1'b0; val = 16'h1111;
    step();
    checks++;
    if (an !== 4'b1110 || seg !== 8'b00001001) begin
      errors++;
      $display("FAIL rst_mid_d0 an=%b seg=%b exp an=1110 seg=00001001", an, seg);
    end
    step(); step(); step();
    checks++;
    if (an !== 4'b1101 || seg !== 8'b00000011) begin
      errors++;
      $display("FAIL rst_mid_d1 an=%b seg=%b exp an=1101 seg=00000011", an, seg);
    end
  endtask

  task automatic test_hex();
    logic [7:0] exp_seg;
`ifdef SEG_HEX_EN
    exp_seg = 8'b00010001;
`else
    exp_seg = 8'hFF;
`endif
    en = 1'b1; val = 16'h000A; dp = 4'b0000; blank_lz = 1'b0;
    do_reset();
    step();
    checks++;
    if (an !== 4'b1110 || seg !== exp_seg) begin
      errors++;
      $display("FAIL hex an=%b seg=%b exp an=1110 seg=%b", an, seg, exp_seg);
    end
  endtask

  task automatic test_single();
    en = 1'b1; val = 16'h0000; dp = 4'b0000;
    do_reset();
    step();
    checks++;
    if (an1 !== 1'b0 || seg1 !== 8'b00011110 || frame_done1 !== 1'b0) begin
      errors++;
      $display("FAIL single_first an=%b seg=%b fd=%b exp an=0 seg=00011110 fd=0", an1, seg1, frame_done1);
    end
    for (int k = 2; k <= 4; k++) begin
      step();
      checks++;
      if (an1 !== 1'b0 || frame_done1 !== 1'b1) begin
        errors++;
        $display("FAIL single_fd k=%0d an=%b fd=%b exp an=0 fd=1", k, an1, frame_done1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_shadow();
    test_enable();
    test_rst_mid();
    test_hex();
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
